// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that funnels NREQ byte-stream requesters
// into a single UART transmitter. A grant locks onto one channel until the
// message ends (req_last) or cfg_maxlen bytes have been sent. An optional
// cfg_gap idle period follows each release.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_chen[NREQ]      per-channel enable (checked only at arbitration)
//   cfg_maxlen[8]       bytes per grant before forced release, 0 = unlimited
//   cfg_gap[8]          idle clocks after each release, 0 = none
//   req_valid/last[NREQ], req_data[NREQ*DW], req_ready[NREQ]  requester side
//   tx_valid, tx_data[DW], tx_ready                           transmitter side
//   grant_id            current or last granted channel
//   busy                high in XFER or GAP
module uart_tx_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      cfg_chen,
  input  logic [7:0]           cfg_maxlen,
  input  logic [7:0]           cfg_gap,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx_valid,
  output logic [DW-1:0]        tx_data,
  input  logic                 tx_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_last;
  logic [7:0]      r_beat;
  logic [7:0]      r_gap;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic            w_beat;
  logic [7:0]      w_beat_nxt;
  logic            w_release;

  assign w_elig = req_valid & cfg_chen;

  // Search starts one past the last grant; IW-bit addition wraps mod NREQ
  // because NREQ is a power of two. i runs to NREQ so the last granted
  // channel itself is considered last.
  always_comb begin
    logic [IW-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      v_idx = r_last + IW'(i);
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (r_state == XFER) begin
      tx_valid           = req_valid[r_grant];
      tx_data            = req_data[32'(r_grant)*DW +: DW];
      req_ready[r_grant] = tx_ready;
    end
  end

  assign w_beat     = (r_state == XFER) && tx_valid && tx_ready;
  assign w_beat_nxt = (r_beat == 8'hFF) ? 8'hFF : r_beat + 8'd1;
  assign w_release  = req_last[r_grant] ||
                      ((cfg_maxlen != 8'd0) && (w_beat_nxt == cfg_maxlen));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NREQ - 1);
      r_beat  <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_beat  <= '0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_beat) begin
            r_beat <= w_beat_nxt;
            if (w_release) begin
              if (cfg_gap != 8'd0) begin
                r_gap   <= cfg_gap;
                r_state <= GAP;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        GAP: begin
          r_gap <= r_gap - 8'd1;
          // <= 1 also recovers from an (unreachable) zero count
          if (r_gap <= 8'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NREQ=4, DW=8).
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cfg_chen;
  logic [7:0]  cfg_maxlen;
  logic [7:0]  cfg_gap;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arb #(.NREQ(4), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_chen   (cfg_chen),
    .cfg_maxlen (cfg_maxlen),
    .cfg_gap    (cfg_gap),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = 4'b0000;
    req_last   = 4'b0000;
    tx_ready   = 1'b0;
    cfg_maxlen = 8'd0;
    cfg_gap    = 8'd0;
    cfg_chen   = 4'hF;
    req_data   = 32'hA3A2A1A0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_chen   = 4'h0;
    cfg_maxlen = 8'd0;
    cfg_gap    = 8'd0;
    req_valid  = 4'h0;
    req_data   = 32'h0;
    req_last   = 4'h0;
    tx_ready   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);

    // First arbitration after reset release: valid 1010 -> channel 1
    req_valid = 4'b1010;
    cfg_chen  = 4'hF;
    req_data  = 32'hA3A2A1A0;
    req_last  = 4'hF;
    rst_n     = 1'b1;
    tick();
    chk("t1_gid", 32'(grant_id), 32'd1);
    chk("t1_txv", 32'(tx_valid), 32'd1);
    chk("t1_txd", 32'(tx_data), 32'hA1);
    chk("t1_rdy0", 32'(req_ready), 32'd0);
    tx_ready = 1'b1;
    #1;
    chk("t1_rdy1", 32'(req_ready), 32'b0010);
    tick();
    chk("t1_rel_busy", 32'(busy), 32'd0);
    chk("t1_rel_txv", 32'(tx_valid), 32'd0);
    chk("t1_rel_txd", 32'(tx_data), 32'd0);
    tick();
    chk("t1_gid3", 32'(grant_id), 32'd3);
    req_valid = 4'b0000;
    #1;
    chk("t1_stall_txv", 32'(tx_valid), 32'd0);
    tick();
    chk("t1_stall_busy", 32'(busy), 32'd1);
    chk("t1_stall_gid", 32'(grant_id), 32'd3);

    // All channels valid, 1-byte messages: 0,1,2,3,0 with an IDLE cycle between
    do_reset();
    req_valid = 4'hF;
    req_last  = 4'hF;
    tx_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gid", 32'(grant_id), 32'(k % 4));
      chk("rr_txv", 32'(tx_valid), 32'd1);
      chk("rr_txd", 32'(tx_data), 32'hA0 + 32'(k % 4));
      tick();
      chk("rr_idle", 32'(busy), 32'd0);
    end

    // maxlen=3: channel 2 sends 3, channel 0 gets a turn, channel 2 resumes
    do_reset();
    cfg_maxlen = 8'd3;
    req_valid  = 4'b0100;
    tick();
    chk("ml_gid2", 32'(grant_id), 32'd2);
    req_valid = 4'b0101;
    req_last  = 4'b0001;
    tx_ready  = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      req_data[23:16] = 8'(8'h20 + b);
      #1;
      chk("ml_txd", 32'(tx_data), 32'h20 + 32'(b));
      tick();
      chk("ml_busy", 32'(busy), (b < 3) ? 32'd1 : 32'd0);
    end
    tick();
    chk("ml_gid0", 32'(grant_id), 32'd0);
    chk("ml_txd0", 32'(tx_data), 32'hA0);
    tick();
    chk("ml_rel0", 32'(busy), 32'd0);
    tick();
    chk("ml_gid2b", 32'(grant_id), 32'd2);
    req_data[23:16] = 8'h24;
    #1;
    chk("ml_txd4", 32'(tx_data), 32'h24);
    tick();
    chk("ml_b4_busy", 32'(busy), 32'd1);
    req_data[23:16] = 8'h25;
    req_last = 4'b0101;
    tick();
    chk("ml_b5_rel", 32'(busy), 32'd0);

    // cfg_gap=10: exactly 10 busy/idle-output cycles, reload-only sampling
    do_reset();
    cfg_gap   = 8'd10;
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    tx_ready  = 1'b1;
    tick();
    chk("gap_gid", 32'(grant_id), 32'd1);
    tick();
    cfg_gap = 8'd3;
    for (int i = 0; i < 10; i++) begin
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_txv", 32'(tx_valid), 32'd0);
      tick();
    end
    chk("gap_end", 32'(busy), 32'd0);
    tick();
    chk("gap_regrant_busy", 32'(busy), 32'd1);
    chk("gap_regrant_gid", 32'(grant_id), 32'd1);
    chk("gap_regrant_txv", 32'(tx_valid), 32'd1);

    // Channel enable cleared mid-message: lock holds, no re-grant afterwards
    do_reset();
    req_valid = 4'b1010;
    tx_ready  = 1'b1;
    tick();
    chk("en_gid1", 32'(grant_id), 32'd1);
    tick();
    cfg_chen = 4'b1101;
    tick();
    chk("en_hold_busy", 32'(busy), 32'd1);
    chk("en_hold_gid", 32'(grant_id), 32'd1);
    req_last = 4'b0010;
    tick();
    chk("en_rel", 32'(busy), 32'd0);
    tick();
    chk("en_gid3", 32'(grant_id), 32'd3);
    req_last = 4'b1010;
    tick();
    tick();
    chk("en_gid3b", 32'(grant_id), 32'd3);

    // Reset pulse mid-XFER on channel 3
    do_reset();
    req_valid = 4'b1000;
    tx_ready  = 1'b1;
    tick();
    chk("mr_gid3", 32'(grant_id), 32'd3);
    tick();
    req_valid = 4'b1001;
    rst_n     = 1'b0;
    tick();
    chk("mr_txv", 32'(tx_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_gid", 32'(grant_id), 32'd0);
    chk("mr_rdy", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_next_gid", 32'(grant_id), 32'd0);
    chk("mr_next_txv", 32'(tx_valid), 32'd1);
    chk("mr_next_txd", 32'(tx_data), 32'hA0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
